// File: rtl/pwm_fade_scheduler.sv
// rtl/pwm_fade_scheduler.sv - ramps the PWM duty cycle toward a target, stepping only on period boundaries
// Parameters are latched on an accepted start so register-file updates never disturb a running fade.
module pwm_fade_scheduler #(
  parameter int DUTY_W = 8,
  parameter logic [DUTY_W-1:0] RESET_DUTY = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic [DUTY_W-1:0] step_size,
  input  logic [7:0]        prescale,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] step_q, step_d;
  logic [7:0]        pre_q, pre_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DUTY_W:0]   sum_up;
  logic [DUTY_W:0]   down_floor;
  logic [DUTY_W-1:0] stepped;

  // One extra bit so the up sum cannot wrap and the down test cannot underflow.
  always_comb begin
    sum_up     = {1'b0, duty_q} + {1'b0, step_q};
    down_floor = {1'b0, target_q} + {1'b0, step_q};
    stepped    = target_q;
    if (target_q > duty_q) begin
      if (sum_up < {1'b0, target_q}) stepped = sum_up[DUTY_W-1:0];
    end else begin
      if ({1'b0, duty_q} > down_floor) stepped = duty_q - step_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    pre_d    = pre_q;
    pcnt_d   = pcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          target_d = target_duty;
          step_d   = (step_size == '0) ? DUTY_W'(1) : step_size;
          pre_d    = prescale;
          pcnt_d   = '0;
          state_d  = (target_duty == duty_q) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (period_end) begin
          if (pcnt_q != pre_q) begin
            pcnt_d = pcnt_q + 8'd1;
          end else begin
            pcnt_d = '0;
            duty_d = stepped;
            if (stepped == target_q) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      duty_q   <= RESET_DUTY;
      target_q <= '0;
      step_q   <= '0;
      pre_q    <= '0;
      pcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      pre_q    <= pre_d;
      pcnt_q   <= pcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
